uncache_arb: RTL and testbench

UNCACHE_ARB -- requirements
Module: uncache_arb

---
 rtl/uncache_arb_if.sv | 24 ++
 rtl/uncache_arb.sv | 126 ++++++++++++
 tb/tb_uncache_arb.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/uncache_arb_if.sv
// Downstream uncached bus: one outstanding request, a ready handshake on the
// request and an rvalid response that also acknowledges writes.
interface uncache_arb_if #(
    parameter int AW = 64
) ();
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [63:0]   bus_wdata;
    logic [7:0]    bus_wstrb;
    logic          bus_ready;
    logic          bus_rvalid;
    logic [63:0]   bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_ready, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_ready, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/uncache_arb.sv
// Round-robin arbiter between ifetch (0) and LSU (1) for a single uncached bus,
// with a per-phase timeout that completes the transaction with an error pulse.
//   state | meaning
//   IDLE  | waiting for req0/req1; grant and latch request fields
//   ADDR  | bus_req high, waiting for bus_ready
//   RESP  | waiting for bus_rvalid
//   DONE  | one-cycle done (and err on timeout) to the granted requester
module uncache_arb #(
    parameter int TIMEOUT = 255,
    parameter int AW      = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [63:0]   wdata0,
    input  logic [63:0]   wdata1,
    input  logic [7:0]    wstrb0,
    input  logic [7:0]    wstrb1,
    output logic          stallreq0,
    output logic          stallreq1,
    output logic          done0,
    output logic          done1,
    output logic          err0,
    output logic          err1,
    output logic [63:0]   rdata,
    uncache_arb_if.master bus
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_t;

    state_t        state;
    logic          grant;
    logic          last_grant;
    logic [CW-1:0] cnt;
    logic          pick;

    // requester 1 wins a tie only when requester 0 was granted last
    assign pick = req1 & (~req0 | ~last_grant);

    assign stallreq0 = req0 & ~((state == DONE) & ~grant);
    assign stallreq1 = req1 & ~((state == DONE) & grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            cnt           <= '0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.bus_wstrb <= '0;
            rdata         <= '0;
            done0         <= 1'b0;
            done1         <= 1'b0;
            err0          <= 1'b0;
            err1          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        grant         <= pick;
                        last_grant    <= pick;
                        bus.bus_we    <= pick ? we1    : we0;
                        bus.bus_addr  <= pick ? addr1  : addr0;
                        bus.bus_wdata <= pick ? wdata1 : wdata0;
                        bus.bus_wstrb <= pick ? wstrb1 : wstrb0;
                        bus.bus_req   <= 1'b1;
                        cnt           <= '0;
                        state         <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.bus_ready) begin
                        bus.bus_req <= 1'b0;
                        cnt         <= '0;
                        state       <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        bus.bus_req <= 1'b0;
                        rdata       <= '0;
                        done0       <= ~grant;
                        done1       <= grant;
                        err0        <= ~grant;
                        err1        <= grant;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.bus_rvalid) begin
                        if (!bus.bus_we) rdata <= bus.bus_rdata;
                        done0 <= ~grant;
                        done1 <= grant;
                        state <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        rdata <= '0;
                        done0 <= ~grant;
                        done1 <= grant;
                        err0  <= ~grant;
                        err1  <= grant;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    err0  <= 1'b0;
                    err1  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uncache_arb.sv
// Directed bench for uncache_arb: inputs change 1ns after the rising edge,
// outputs are checked 2ns after it.
module tb_uncache_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [63:0] addr0, addr1, wdata0, wdata1;
    logic [7:0]  wstrb0, wstrb1;
    logic        stallreq0, stallreq1, done0, done1, err0, err1;
    logic [63:0] rdata;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    uncache_arb_if #(.AW(64)) bus ();

    uncache_arb #(.TIMEOUT(8), .AW(64)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .wstrb0(wstrb0), .wstrb1(wstrb1),
        .stallreq0(stallreq0), .stallreq1(stallreq1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .rdata(rdata), .bus(bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; wstrb0 = '0; wstrb1 = '0;
        bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = '0;

        // reset values, stallreq still combinational under reset
        tick; tick; #1;
        check("rst stall0", 64'(stallreq0), 64'd1);
        check("rst bus_req", 64'(bus.bus_req), 64'd0);
        check("rst bus_addr", bus.bus_addr, 64'd0);
        check("rst bus_wstrb", 64'(bus.bus_wstrb), 64'd0);
        check("rst rdata", rdata, 64'd0);
        check("rst done/err", 64'({done0, done1, err0, err1}), 64'd0);
        tick; rst = 1'b0; req0 = 1'b0;

        // single read from requester 1, no bus wait
        tick; req1 = 1'b1; addr1 = 64'hA000_0048; we1 = 1'b0;
        bus.bus_ready = 1'b1; bus.bus_rvalid = 1'b1; bus.bus_rdata = 64'h1122334455667788; #1;
        check("rd c0 stall1", 64'(stallreq1), 64'd1);
        check("rd c0 bus_req", 64'(bus.bus_req), 64'd0);
        tick; #1;
        check("rd c1 bus_req", 64'(bus.bus_req), 64'd1);
        check("rd c1 bus_addr", bus.bus_addr, 64'hA000_0048);
        check("rd c1 bus_we", 64'(bus.bus_we), 64'd0);
        check("rd c1 stall1", 64'(stallreq1), 64'd1);
        tick; #1;
        check("rd c2 bus_req", 64'(bus.bus_req), 64'd0);
        check("rd c2 done1", 64'(done1), 64'd0);
        check("rd c2 stall1", 64'(stallreq1), 64'd1);
        tick; #1;
        check("rd c3 done1", 64'(done1), 64'd1);
        check("rd c3 err1", 64'(err1), 64'd0);
        check("rd c3 rdata", rdata, 64'h1122334455667788);
        check("rd c3 stall1", 64'(stallreq1), 64'd0);
        tick; req1 = 1'b0; #1;
        check("rd c4 done1", 64'(done1), 64'd0);

        // fresh reset, then a tie: 0 first; 0 re-requests so the next tie goes to 1
        tick; rst = 1'b1; tick; rst = 1'b0;
        tick; req0 = 1'b1; req1 = 1'b1; addr0 = 64'h100; addr1 = 64'h200;
        bus.bus_rdata = 64'h0A0A0A0A0A0A0A0A; #1;
        check("tie c0 stall0", 64'(stallreq0), 64'd1);
        check("tie c0 stall1", 64'(stallreq1), 64'd1);
        tick; #1;
        check("tie1 bus_addr", bus.bus_addr, 64'h100);
        tick; tick; #1;
        check("tie1 done0", 64'(done0), 64'd1);
        check("tie1 done1", 64'(done1), 64'd0);
        check("tie1 stall0", 64'(stallreq0), 64'd0);
        check("tie1 stall1", 64'(stallreq1), 64'd1);
        check("tie1 rdata", rdata, 64'h0A0A0A0A0A0A0A0A);
        tick; addr0 = 64'h300; bus.bus_rdata = 64'h0B0B0B0B0B0B0B0B; #1;
        tick; #1;
        check("tie2 bus_addr", bus.bus_addr, 64'h200);
        tick; tick; #1;
        check("tie2 done1", 64'(done1), 64'd1);
        check("tie2 done0", 64'(done0), 64'd0);
        check("tie2 stall0", 64'(stallreq0), 64'd1);
        check("tie2 rdata", rdata, 64'h0B0B0B0B0B0B0B0B);
        tick; req1 = 1'b0; bus.bus_rdata = 64'h0C0C0C0C0C0C0C0C; #1;
        tick; #1;
        check("tie3 bus_addr", bus.bus_addr, 64'h300);
        tick; tick; #1;
        check("tie3 done0", 64'(done0), 64'd1);
        check("tie3 rdata", rdata, 64'h0C0C0C0C0C0C0C0C);
        tick; req0 = 1'b0; #1;

        // write with 5 cycles of backpressure, requester fields scrambled in flight
        tick; req0 = 1'b1; we0 = 1'b1; addr0 = 64'h40; wdata0 = 64'hDEADBEEFCAFEF00D;
        wstrb0 = 8'h0F; bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0;
        bus.bus_rdata = 64'h5555; #1;
        for (int i = 1; i <= 6; i++) begin
            tick;
            if (i == 1) begin addr0 = '1; wdata0 = '0; wstrb0 = 8'hF0; we0 = 1'b0; end
            if (i == 6) bus.bus_ready = 1'b1;
            #1;
            check($sformatf("wr addr%0d bus_req", i), 64'(bus.bus_req), 64'd1);
            check($sformatf("wr addr%0d bus_addr", i), bus.bus_addr, 64'h40);
            check($sformatf("wr addr%0d bus_wdata", i), bus.bus_wdata, 64'hDEADBEEFCAFEF00D);
            check($sformatf("wr addr%0d bus_wstrb", i), 64'(bus.bus_wstrb), 64'h0F);
            check($sformatf("wr addr%0d bus_we", i), 64'(bus.bus_we), 64'd1);
        end
        tick; bus.bus_ready = 1'b0; #1;
        check("wr resp bus_req", 64'(bus.bus_req), 64'd0);
        tick; bus.bus_rvalid = 1'b1; #1;
        check("wr rvalid done0", 64'(done0), 64'd0);
        tick; bus.bus_rvalid = 1'b0; #1;
        check("wr done0", 64'(done0), 64'd1);
        check("wr err0", 64'(err0), 64'd0);
        check("wr rdata kept", rdata, 64'h0C0C0C0C0C0C0C0C);
        tick; req0 = 1'b0; we0 = 1'b0; #1;

        // timeout in ADDR after 8 cycles, late rvalid ignored
        tick; req1 = 1'b1; addr1 = 64'h80; we1 = 1'b0; #1;
        for (int i = 1; i <= 8; i++) begin
            tick; #1;
            check($sformatf("to addr%0d bus_req", i), 64'(bus.bus_req), 64'd1);
            check($sformatf("to addr%0d done1", i), 64'(done1), 64'd0);
        end
        tick; #1;
        check("to done1", 64'(done1), 64'd1);
        check("to err1", 64'(err1), 64'd1);
        check("to rdata", rdata, 64'd0);
        check("to bus_req", 64'(bus.bus_req), 64'd0);
        tick; req1 = 1'b0; bus.bus_rvalid = 1'b1; bus.bus_rdata = 64'h9999; #1;
        check("to post done/err", 64'({done1, err1}), 64'd0);
        tick; #1;
        check("to late rvalid rdata", rdata, 64'd0);
        check("to late done1", 64'(done1), 64'd0);
        tick; bus.bus_rvalid = 1'b0; #1;

        // reset while waiting in RESP, then the still-held request runs normally
        tick; req0 = 1'b1; we0 = 1'b0; addr0 = 64'h10; bus.bus_ready = 1'b1; #1;
        tick; #1;
        check("rr c1 bus_req", 64'(bus.bus_req), 64'd1);
        tick; rst = 1'b1; #1;
        tick; rst = 1'b0; bus.bus_rvalid = 1'b1; bus.bus_rdata = 64'h7777; #1;
        check("rr c3 done/err", 64'({done0, done1, err0, err1}), 64'd0);
        check("rr c3 bus_req", 64'(bus.bus_req), 64'd0);
        check("rr c3 bus_addr", bus.bus_addr, 64'd0);
        tick; #1;
        check("rr c4 bus_req", 64'(bus.bus_req), 64'd1);
        check("rr c4 bus_addr", bus.bus_addr, 64'h10);
        check("rr c4 done0", 64'(done0), 64'd0);
        tick; tick; #1;
        check("rr done0", 64'(done0), 64'd1);
        check("rr err0", 64'(err0), 64'd0);
        check("rr rdata", rdata, 64'h7777);
        tick; req0 = 1'b0; #1;

        // back-to-back: req1 held through done, second transaction latches new addr1
        tick; req1 = 1'b1; addr1 = 64'h1000; we1 = 1'b0; bus.bus_rdata = 64'h1; #1;
        tick; tick; tick; #1;
        check("b2b done1 a", 64'(done1), 64'd1);
        check("b2b rdata a", rdata, 64'h1);
        addr1 = 64'h2000; bus.bus_rdata = 64'h2;
        tick; #1;
        check("b2b idle done1", 64'(done1), 64'd0);
        check("b2b idle bus_req", 64'(bus.bus_req), 64'd0);
        check("b2b idle stall1", 64'(stallreq1), 64'd1);
        tick; #1;
        check("b2b bus_addr b", bus.bus_addr, 64'h2000);
        check("b2b bus_req b", 64'(bus.bus_req), 64'd1);
        tick; tick; #1;
        check("b2b done1 b", 64'(done1), 64'd1);
        check("b2b rdata b", rdata, 64'h2);
        tick; req1 = 1'b0; bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
